// File: rtl/alu_md.sv
// alu_md: single-cycle ALU plus an iterative multiply/divide unit with HI/LO.
// Ports: CLK, nRST (async, active low); a, b operands; aluop selects the
// combinational op driving out/negative/zero/overflow; md_start/md_op launch
// MULT/MULTU/DIV/DIVU and md_busy/md_done/md_divzero report on hi/lo.
// Define MULDIV_EARLY_EXIT_EN to end multiplies once the remaining
// multiplier bits are all zero.
module alu_md #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluop,
  output logic [WIDTH-1:0] out,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  input  logic             md_start,
  input  logic [1:0]       md_op,
  output logic             md_busy,
  output logic             md_done,
  output logic             md_divzero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int M  = WIDTH - 1;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CMAX = CW'(WIDTH);

  localparam logic [3:0] OP_SLL  = 4'b0000;
  localparam logic [3:0] OP_SRL  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;

  logic [WIDTH-1:0] add_r;
  logic [WIDTH-1:0] sub_r;

  assign add_r = a + b;
  assign sub_r = a - b;

  always_comb begin
    out      = '0;
    overflow = 1'b0;
    case (aluop)
      OP_SLL:  out = a << b[SHW-1:0];
      OP_SRL:  out = a >> b[SHW-1:0];
      OP_ADD: begin
        out      = add_r;
        overflow = ~(a[M] ^ b[M]) & (add_r[M] ^ a[M]);
      end
      OP_SUB: begin
        out      = sub_r;
        overflow = (a[M] ^ b[M]) & ~(b[M] ^ sub_r[M]);
      end
      OP_AND:  out = a & b;
      OP_OR:   out = a | b;
      OP_XOR:  out = a ^ b;
      OP_NOR:  out = ~(a | b);
      OP_SLT:  out = {{M{1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: out = {{M{1'b0}}, a < b};
      default: out = '0;
    endcase
  end

  assign negative = out[M];
  assign zero     = (out == '0);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } md_state_t;

  md_state_t state;
  md_state_t nxt;

  logic [1:0]         op_q;
  logic               neg_q;
  logic               rneg_q;
  logic               dz_q;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] opb;
  logic [WIDTH-1:0]   mpl;

  // Signed ops run on magnitudes; signs are restored in FIN.
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] ma;
  logic [WIDTH-1:0] mb;

  assign sa = ~md_op[0] & a[M];
  assign sb = ~md_op[0] & b[M];
  assign ma = sa ? -a : a;
  assign mb = sb ? -b : b;

  logic early;
`ifdef MULDIV_EARLY_EXIT_EN
  assign early = ~op_q[1] & (mpl == '0);
`else
  assign early = 1'b0;
`endif

  logic last;
  assign last = (cnt == CMAX) | early;

  // Restoring divide step: acc = {remainder, dividend/quotient}.
  logic [WIDTH:0]   dt;
  logic [WIDTH:0]   dd;
  logic [WIDTH-1:0] rn;

  assign dt = {acc[2*WIDTH-1:WIDTH], acc[M]};
  assign dd = dt - {1'b0, opb[M:0]};
  assign rn = dd[WIDTH] ? dt[M:0] : dd[M:0];

  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;

  assign prod_s = neg_q ? -acc : acc;
  assign quo    = acc[M:0];
  assign rem    = acc[2*WIDTH-1:WIDTH];
  assign quo_s  = dz_q ? '1 : (neg_q ? -quo : quo);
  assign rem_s  = rneg_q ? -rem : rem;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (md_start) nxt = CALC;
      CALC:    if (last) nxt = FIN;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign md_busy = (state != IDLE);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      op_q       <= '0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      dz_q       <= 1'b0;
      cnt        <= '0;
      acc        <= '0;
      opb        <= '0;
      mpl        <= '0;
      hi         <= '0;
      lo         <= '0;
      md_done    <= 1'b0;
      md_divzero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          md_done    <= 1'b0;
          md_divzero <= 1'b0;
          if (md_start) begin
            op_q   <= md_op;
            neg_q  <= sa ^ sb;
            rneg_q <= sa;
            dz_q   <= md_op[1] & (b == '0);
            cnt    <= '0;
            if (md_op[1]) begin
              acc <= {{WIDTH{1'b0}}, ma};
              opb <= {{WIDTH{1'b0}}, mb};
              mpl <= '0;
            end else begin
              acc <= '0;
              opb <= {{WIDTH{1'b0}}, ma};
              mpl <= mb;
            end
          end
        end
        CALC: begin
          if (!last) begin
            cnt <= cnt + CW'(1);
            if (op_q[1]) begin
              acc <= {rn, acc[M-1:0], ~dd[WIDTH]};
            end else begin
              if (mpl[0]) acc <= acc + opb;
              opb <= opb << 1;
              mpl <= mpl >> 1;
            end
          end
        end
        FIN: begin
          if (op_q[1]) begin
            hi <= rem_s;
            lo <= quo_s;
          end else begin
            hi <= prod_s[2*WIDTH-1:WIDTH];
            lo <= prod_s[M:0];
          end
          md_done    <= 1'b1;
          md_divzero <= dz_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md: directed vectors for the ALU path and the multiply/divide unit.
// Checks results, flags, latency, busy-start rejection and async reset.
module tb_alu_md;

  logic        CLK;
  logic        nRST;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  aluop;
  logic [31:0] out;
  logic        negative;
  logic        zero;
  logic        overflow;
  logic        md_start;
  logic [1:0]  md_op;
  logic        md_busy;
  logic        md_done;
  logic        md_divzero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  alu_md #(.WIDTH(32)) dut (
    .CLK(CLK), .nRST(nRST), .a(a), .b(b), .aluop(aluop),
    .out(out), .negative(negative), .zero(zero), .overflow(overflow),
    .md_start(md_start), .md_op(md_op), .md_busy(md_busy),
    .md_done(md_done), .md_divzero(md_divzero), .hi(hi), .lo(lo)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic alu_vec(input string tag, input logic [3:0] op,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eout, input logic eov);
    aluop = op; a = x; b = y;
    #1;
    chk({tag, "_out"}, out, eout);
    chk({tag, "_ovf"}, overflow, eov);
    chk({tag, "_neg"}, negative, eout[31]);
    chk({tag, "_zero"}, zero, eout == 32'h0);
  endtask

  function automatic int mlat(input logic [1:0] op, input logic [31:0] y);
    int n;
    logic [31:0] m;
    n = 0;
    m = (op == 2'd0 && y[31]) ? -y : y;
`ifdef MULDIV_EARLY_EXIT_EN
    if (op < 2'd2) begin
      while (m != 32'h0) begin
        n++;
        m = m >> 1;
      end
      return n + 2;
    end
`endif
    return 34 + n - n + 0 * int'(m[0]);
  endfunction

  task automatic md_run(input string tag, input logic [1:0] op,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edz, input bit poke);
    int n;
    @(negedge CLK);
    md_start = 1'b1; md_op = op; a = x; b = y;
    @(posedge CLK);
    #1;
    md_start = 1'b0; md_op = ~op; a = 32'hDEADBEEF; b = 32'h0;
    chk({tag, "_busy"}, md_busy, 1'b1);
    n = 0;
    while (n < 100) begin
      @(posedge CLK);
      #1;
      n++;
      if (md_done) break;
      if (poke && n == 3) begin md_start = 1'b1; md_op = 2'd3; end
      if (poke && n == 4) md_start = 1'b0;
    end
    chk({tag, "_lat"}, n, mlat(op, y));
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_lo"}, lo, elo);
    chk({tag, "_dz"}, md_divzero, edz);
  endtask

  initial begin
    nRST = 1'b0; md_start = 1'b0; md_op = 2'd0;
    a = '0; b = '0; aluop = 4'b0000;
    #12;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", md_busy, 1'b0);
    chk("rst_done", md_done, 1'b0);
    chk("rst_dz", md_divzero, 1'b0);
    @(negedge CLK);
    nRST = 1'b1;

    alu_vec("add_ovf", 4'b0010, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b1);
    alu_vec("add_wrap", 4'b0010, 32'h80000000, 32'h80000000, 32'h0, 1'b1);
    alu_vec("add_ok", 4'b0010, 32'h5, 32'hFFFFFFFE, 32'h3, 1'b0);
    alu_vec("sub_zero", 4'b0011, 32'h5, 32'h5, 32'h0, 1'b0);
    alu_vec("sub_ovf", 4'b0011, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b1);
    alu_vec("sll", 4'b0000, 32'h1, 32'h24, 32'h10, 1'b0);
    alu_vec("srl", 4'b0001, 32'h80000000, 32'h1F, 32'h1, 1'b0);
    alu_vec("and", 4'b0100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0);
    alu_vec("or", 4'b0101, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0);
    alu_vec("xor", 4'b0110, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0);
    alu_vec("nor", 4'b0111, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h000F000F, 1'b0);
    alu_vec("slt", 4'b1010, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0);
    alu_vec("sltu", 4'b1011, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0);
    alu_vec("undef", 4'b1000, 32'h7FFFFFFF, 32'h1, 32'h0, 1'b0);

    md_run("multu_max", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
    md_run("multu_3x5", 2'd1, 32'h3, 32'h5, 32'h0, 32'hF, 1'b0, 1'b0);
    md_run("mult_neg", 2'd0, 32'hFFFFFFFD, 32'h5,
           32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0);
    md_run("mult_min", 2'd0, 32'h80000000, 32'h80000000,
           32'h40000000, 32'h0, 1'b0, 1'b0);
    md_run("div_m7_2", 2'd2, 32'hFFFFFFF9, 32'h2,
           32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b1);
    @(posedge CLK);
    #1;
    chk("poke_idle", md_busy, 1'b0);
    chk("poke_done", md_done, 1'b0);
    md_run("div_7_m2", 2'd2, 32'h7, 32'hFFFFFFFE,
           32'h1, 32'hFFFFFFFD, 1'b0, 1'b0);
    md_run("divu_7_0", 2'd3, 32'h7, 32'h0, 32'h7, 32'hFFFFFFFF, 1'b1, 1'b0);
    md_run("div_min_m1", 2'd2, 32'h80000000, 32'hFFFFFFFF,
           32'h0, 32'h80000000, 1'b0, 1'b0);
    md_run("divu_100_7", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);
    md_run("div_m7_0", 2'd2, 32'hFFFFFFF9, 32'h0,
           32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 1'b0);

    @(negedge CLK);
    md_start = 1'b1; md_op = 2'd1; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    @(posedge CLK);
    #1;
    md_start = 1'b0;
    repeat (11) @(posedge CLK);
    #3;
    chk("mid_busy", md_busy, 1'b1);
    nRST = 1'b0;
    #1;
    chk("arst_hi", hi, 32'h0);
    chk("arst_lo", lo, 32'h0);
    chk("arst_busy", md_busy, 1'b0);
    chk("arst_done", md_done, 1'b0);
    @(negedge CLK);
    nRST = 1'b1;
    md_run("post_rst", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
